// File: rtl/cnn_pkg.sv
// Shared constants and encodings for the cnn output-side blocks.
// Consumed by dom_collector and dom_argmax_tracker.
package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_DRAIN   = 1'b1
  } state_t;

  localparam int ERR_W    = 3;
  localparam int ERR_DUP  = 0;
  localparam int ERR_MISS = 1;
  localparam int ERR_OVR  = 2;

endpackage

// File: rtl/dom_argmax_tracker.sv
// Running maximum over a stream of (value, index) pairs; strict-greater compare
// keeps the earliest index on ties when indices arrive in ascending order.
module dom_argmax_tracker
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int ADDR_W = cnn_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_update,
  input  logic [DATA_W-1:0] i_value,
  input  logic [ADDR_W-1:0] i_index,
  output logic [ADDR_W-1:0] o_max_idx
);

  logic [DATA_W-1:0] r_max_val;
  logic [ADDR_W-1:0] r_max_idx;
  logic              w_greater;

  // A cleared tracker holds (0, 0), so an all-zero frame reports index 0.
  assign w_greater = (i_value > r_max_val);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_max_val <= '0;
      r_max_idx <= '0;
    end else if (i_clear) begin
      r_max_val <= '0;
      r_max_idx <= '0;
    end else if (i_update && w_greater) begin
      r_max_val <= i_value;
      r_max_idx <= i_index;
    end
  end

  assign o_max_idx = r_max_idx;

endmodule

// File: rtl/dom_collector.sv
// Captures one frame of cnn output words by address, then drains it in index
// order over a valid/ready stream while tracking the argmax.
module dom_collector
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int DEPTH  = cnn_pkg::DEPTH,
  parameter int ADDR_W = cnn_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] dom_data,
  input  logic [ADDR_W-1:0] dom_address,
  input  logic              dom_ready,
  input  logic              finish,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic [ADDR_W-1:0] argmax_idx,
  output logic              argmax_valid,
  output logic              busy,
  output logic [2:0]        err
);

  state_t            r_state;
  logic [DATA_W-1:0] r_buf [DEPTH];
  logic [DEPTH-1:0]  r_mask;
  logic              r_drained;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_index;
  logic              r_out_last;
  logic              r_argmax_valid;
  logic [2:0]        r_err;

  logic              w_wr_en;
  logic              w_new_frame;
  logic              w_start;
  logic              w_hs;
  logic [DEPTH-1:0]  w_mask_base;
  logic [DEPTH-1:0]  w_mask_next;
  logic              w_dup;
  logic [ADDR_W-1:0] w_next_idx;
  logic [ADDR_W-1:0] w_rd_idx;
  logic [DATA_W-1:0] w_rd_data;
  logic [ADDR_W-1:0] w_trk_idx;

  assign w_wr_en     = dom_ready && (r_state == ST_COLLECT);
  assign w_new_frame = w_wr_en && r_drained;
  assign w_start     = finish && (r_state == ST_COLLECT);
  assign w_hs        = r_out_valid && out_ready;
  assign w_next_idx  = r_out_index + 1'b1;

  // The first write after a drain sees an empty mask, so it never flags a duplicate.
  assign w_mask_base = w_new_frame ? '0 : r_mask;
  assign w_dup       = w_wr_en && w_mask_base[dom_address];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
    assign w_mask_next[gi] = w_mask_base[gi] |
                             (w_wr_en && (dom_address == ADDR_W'(gi)));
  end

  // Forward a write coinciding with finish so beat 0 sees it.
  assign w_rd_idx  = w_start ? '0 : w_next_idx;
  assign w_rd_data = (w_wr_en && (dom_address == w_rd_idx)) ? dom_data :
                     (w_mask_next[w_rd_idx] ? r_buf[w_rd_idx] : '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_buf[dom_address] <= dom_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_COLLECT;
      r_mask         <= '0;
      r_drained      <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_index    <= '0;
      r_out_last     <= 1'b0;
      r_argmax_valid <= 1'b0;
      r_err          <= '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          r_mask <= w_mask_next;
          if (w_dup) begin
            r_err[ERR_DUP] <= 1'b1;
          end
          if (w_new_frame) begin
            r_drained      <= 1'b0;
            r_argmax_valid <= 1'b0;
          end
          if (finish) begin
            r_state     <= ST_DRAIN;
            r_out_valid <= 1'b1;
            r_out_index <= '0;
            r_out_data  <= w_rd_data;
            r_out_last  <= (DEPTH == 1);
            if (!(&w_mask_next)) begin
              r_err[ERR_MISS] <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (dom_ready) begin
            r_err[ERR_OVR] <= 1'b1;
          end
          if (w_hs) begin
            if (r_out_last) begin
              r_state        <= ST_COLLECT;
              r_out_valid    <= 1'b0;
              r_out_data     <= '0;
              r_out_index    <= '0;
              r_out_last     <= 1'b0;
              r_argmax_valid <= 1'b1;
              r_drained      <= 1'b1;
            end else begin
              r_out_index <= w_next_idx;
              r_out_data  <= w_rd_data;
              r_out_last  <= (w_next_idx == ADDR_W'(DEPTH - 1));
            end
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  // Tracker resets with the frame that supersedes the reported result.
  dom_argmax_tracker #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_argmax (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_new_frame),
    .i_update  (w_hs),
    .i_value   (r_out_data),
    .i_index   (r_out_index),
    .o_max_idx (w_trk_idx)
  );

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_index    = r_out_index;
  assign out_last     = r_out_last;
  assign argmax_idx   = w_trk_idx;
  assign argmax_valid = r_argmax_valid;
  assign busy         = (r_state == ST_DRAIN);
  assign err          = r_err;

endmodule

// File: tb/tb_dom_collector.sv
// Directed bench for dom_collector: frame-level model plus per-cycle compare.
module tb_dom_collector;

  localparam int DW = 16;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] dom_data = '0;
  logic [AW-1:0] dom_address = '0;
  logic          dom_ready = 1'b0;
  logic          finish = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic [AW-1:0] argmax_idx;
  logic          argmax_valid;
  logic          busy;
  logic [2:0]    err;

  always #5 clock = ~clock;

  dom_collector dut (
    .clock        (clock),
    .reset        (reset),
    .dom_data     (dom_data),
    .dom_address  (dom_address),
    .dom_ready    (dom_ready),
    .finish       (finish),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_last     (out_last),
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid),
    .busy         (busy),
    .err          (err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame-level model: buffer contents, written set, flags, current beat.
  logic [DW-1:0] m_buf [D];
  logic [D-1:0]  m_mask;
  logic [2:0]    m_err;
  bit            m_busy, m_drained, m_av;
  int            m_beat;
  logic [AW-1:0] m_aidx, m_pend;
  logic [DW-1:0] rec [D];

  function automatic logic [DW-1:0] mval(input int i);
    return m_mask[i] ? m_buf[i] : '0;
  endfunction

  function automatic logic [AW-1:0] frame_argmax();
    int best = 0;
    for (int i = 1; i < D; i++) if (mval(i) > mval(best)) best = i;
    return AW'(best);
  endfunction

  always @(negedge reset) begin
    for (int i = 0; i < D; i++) begin m_buf[i] = '0; rec[i] = '0; end
    m_mask = '0; m_err = '0; m_busy = 0; m_drained = 0; m_av = 0;
    m_beat = 0; m_aidx = '0; m_pend = '0;
  end

  always @(posedge clock) begin
    if (reset) begin
      if (!m_busy) begin
        if (dom_ready) begin
          if (m_drained) begin m_mask = '0; m_av = 0; m_drained = 0; end
          if (m_mask[dom_address]) m_err[0] = 1'b1;
          m_buf[dom_address] = dom_data;
          m_mask[dom_address] = 1'b1;
        end
        if (finish) begin
          if (m_mask != '1) m_err[1] = 1'b1;
          m_pend = frame_argmax();
          m_busy = 1; m_beat = 0;
        end
      end else begin
        if (dom_ready) m_err[2] = 1'b1;
        if (out_ready) begin
          rec[m_beat] = out_data;
          if (m_beat == D - 1) begin
            m_busy = 0; m_av = 1; m_aidx = m_pend; m_drained = 1;
          end else begin
            m_beat++;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      check("busy", busy, m_busy);
      check("out_valid", out_valid, m_busy);
      check("err", err, m_err);
      check("argmax_valid", argmax_valid, m_av);
      if (m_av) check("argmax_idx", argmax_idx, m_aidx);
      if (m_busy) begin
        check("out_index", out_index, m_beat);
        check("out_data", out_data, mval(m_beat));
        check("out_last", out_last, m_beat == D - 1);
      end
    end
  end

  task automatic wr(input int a, input int d, input bit fin);
    @(negedge clock);
    dom_ready = 1'b1; dom_address = AW'(a); dom_data = DW'(d); finish = fin;
    @(negedge clock);
    dom_ready = 1'b0; finish = 1'b0;
  endtask

  task automatic start();
    @(negedge clock);
    finish = 1'b1;
    @(negedge clock);
    finish = 1'b0;
  endtask

  task automatic drain(input logic [3:0] pat, input int n);
    int c = 0;
    logic [3:0] p = pat;
    while (busy && c < 200) begin
      out_ready = p[c % n];
      @(negedge clock);
      c++;
    end
    out_ready = 1'b0;
    check("drain_done", busy, 0);
  endtask

  initial begin
    int f1 [D];
    int f5 [D];
    f1 = '{10, 50, 30, 70, 20, 70, 5, 1};
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_argmax_valid", argmax_valid, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clock); reset = 1'b1;

    // Frame 1: in order, full throughput
    for (int i = 0; i < D; i++) wr(i, f1[i], 0);
    start();
    drain(4'b0001, 1);
    $display("frame1 argmax_idx=%0d err=%0d", argmax_idx, err);
    check("f1_argmax_idx", argmax_idx, 3);
    check("f1_argmax_valid", argmax_valid, 1);
    check("f1_err", err, 0);
    check("f1_beat3", rec[3], 70);
    check("f1_beat7", rec[7], 1);

    // Frame 2: out-of-order writes, stalls 1,0,0,1
    wr(7, 300, 0);
    check("f2_argmax_cleared", argmax_valid, 0);
    wr(2, 400, 0); wr(0, 5, 0); wr(1, 6, 0);
    wr(3, 400, 0); wr(4, 2, 0); wr(5, 1, 0); wr(6, 399, 0);
    start();
    drain(4'b1001, 4);
    $display("frame2 argmax_idx=%0d err=%0d", argmax_idx, err);
    check("f2_argmax_idx", argmax_idx, 2);
    check("f2_beat7", rec[7], 300);

    // Frame 3: duplicate on addr 1, addr 4 missing
    wr(1, 100, 0); wr(1, 200, 0);
    wr(0, 7, 0); wr(2, 8, 0); wr(3, 9, 0); wr(5, 10, 0); wr(6, 11, 0); wr(7, 12, 0);
    start();
    drain(4'b0001, 1);
    $display("frame3 beat1=%0d beat4=%0d err=%0d", rec[1], rec[4], err);
    check("f3_beat1", rec[1], 200);
    check("f3_beat4", rec[4], 0);
    check("f3_err", err, 3'b011);
    check("f3_argmax_idx", argmax_idx, 1);

    // Frame 4: write coincident with finish, then overrun during drain
    for (int i = 0; i < D - 1; i++) wr(i, 11 * (i + 1), 0);
    wr(7, 9, 1);
    wr(0, 999, 0);
    drain(4'b0001, 1);
    $display("frame4 beat0=%0d beat7=%0d err=%0d", rec[0], rec[7], err);
    check("f4_beat0", rec[0], 11);
    check("f4_beat7", rec[7], 9);
    check("f4_err_ovr", err[2], 1);
    check("f4_argmax_idx", argmax_idx, 6);

    // Frame 5: reset after beat 3
    for (int i = 0; i < D; i++) begin f5[i] = 3 * i + 1; wr(i, f5[i], 0); end
    start();
    out_ready = 1'b1;
    repeat (4) @(negedge clock);
    check("f5_index_before_rst", out_index, 4);
    #2 reset = 1'b0;
    #1;
    $display("mid-drain reset out_valid=%0d busy=%0d err=%0d", out_valid, busy, err);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_argmax_valid", argmax_valid, 0);
    check("mid_rst_err", err, 0);
    out_ready = 1'b0;
    @(negedge clock); reset = 1'b1;

    // Frame 6: all zeros after reset
    for (int i = 0; i < D; i++) wr(i, 0, 0);
    start();
    drain(4'b0001, 1);
    $display("frame6 argmax_idx=%0d err=%0d", argmax_idx, err);
    check("f6_argmax_idx", argmax_idx, 0);
    check("f6_argmax_valid", argmax_valid, 1);
    check("f6_err", err, 0);
    check("f6_beat7", rec[7], 0);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dom_collector.md
Name: dom_collector

Overview:
- Downstream consumer of the cnn output port (dom_data / dom_address / dom_ready / finish).
- Captures one frame of DEPTH output words into a local buffer, indexed by dom_address.
- On finish, drains the frame in index order over a valid/ready stream to the host, computing the argmax on the fly.
- Sits between cnn and the host/readout interface in MyDesign.

Parameters:
DATA_W, 16, width of each output word (matches dom_data)
DEPTH, 8, output words per frame
ADDR_W, 3, index width; DEPTH = 2**ADDR_W

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; clears all state immediately
dom_data  input  DATA_W  output word from cnn, non-negative (ReLU-truncated), compared as unsigned
dom_address  input  ADDR_W  index of dom_data
dom_ready  input  1  one-cycle write strobe for dom_data/dom_address
finish  input  1  frame-complete pulse from cnn
out_valid  output  1  drain word available
out_ready  input  1  host accepts the drain word
out_data  output  DATA_W  buffered word at out_index (0 if never written)
out_index  output  ADDR_W  index of out_data
out_last  output  1  high with out_valid when out_index == DEPTH-1
argmax_idx  output  ADDR_W  index of the largest word in the last drained frame
argmax_valid  output  1  argmax_idx valid
busy  output  1  high in DRAIN
err  output  3  sticky flags: [0] duplicate write, [1] missing entry, [2] overrun

Behaviour:
- Reset (reset=0, async): state COLLECT; buffer and written-mask cleared; all outputs 0.
- States: COLLECT, DRAIN.
- COLLECT:
  - dom_ready=1 writes buf[dom_address] <= dom_data and sets mask[dom_address].
  - If mask[dom_address] was already set, the write still happens and err[0] is set.
  - The first dom_ready after a completed drain clears argmax_valid and the mask, then writes (the mask is cleared and this entry marked in the same cycle).
  - finish=1 moves to DRAIN next cycle. If any mask bit is 0 at that point, err[1] is set.
  - dom_ready and finish in the same cycle: the word is captured first, then the state moves to DRAIN.
  - finish with an empty mask is legal: the frame drains as all zeros and err[1] is set.
- DRAIN:
  - out_valid is registered; it is high from the first cycle after finish, starting at out_index=0.
  - A handshake (out_valid & out_ready) advances out_index by 1.
  - out_data, out_index and out_last are held stable while out_valid & ~out_ready.
  - out_data is buf[idx] if mask[idx] is set, else 0.
  - A running max updates on each handshake. Comparison is strictly greater, so on ties the lowest index wins.
  - The handshake with out_last=1 returns the state to COLLECT next cycle with out_valid=0, argmax_idx final and argmax_valid=1.
  - Minimum drain: DEPTH cycles with out_ready held high.
  - dom_ready during DRAIN: the data is dropped, err[2] is set, and the buffer is unchanged.
  - finish during DRAIN is ignored.
- busy = (state == DRAIN).
- err bits are cleared only by reset.
- argmax_valid/argmax_idx hold after a drain until the next frame's first dom_ready.
- Reset asserted mid-DRAIN aborts the drain: out_valid drops asynchronously and no partial argmax is reported.
- No arithmetic beyond the unsigned DATA_W compare and the ADDR_W index increment. The index wraps to 0 only through the COLLECT return.

Decomposition:
- Shared package cnn_pkg: DATA_W, DEPTH, ADDR_W constants; state encoding (COLLECT=0, DRAIN=1); err bit positions (ERR_DUP=0, ERR_MISS=1, ERR_OVR=2).
- One sub-module, dom_argmax_tracker: running max value/index register with clear, update strobe, and strict-greater compare. It is reusable by later classifier stages.
- The buffer is an inline DEPTH x DATA_W register array plus a DEPTH-bit mask.

Test Plan:
- Full frame in order: write addr 0..7 with data 10,50,30,70,20,70,5,1, finish, out_ready=1 -> 8 consecutive beats, data as written, out_last on beat 7, argmax_idx=3 (tie with 5, lower wins), argmax_valid=1, err=0.
- Out-of-order writes plus back-pressure: write addr 7,2,0,... with out_ready toggling 1,0,0,1 -> out_data/out_index held during stalls, beats still emitted in index order 0..7.
- Missing and duplicate: write addr 1 twice (100 then 200), skip addr 4, finish -> beat1=200, beat4=0, err=3'b011.
- Overrun and simultaneity: dom_ready coincident with finish on addr 7 (data 9) is captured; dom_ready during DRAIN (addr 0, data 999) -> beat0 unchanged, err[2]=1.
- Reset mid-drain: pull reset low after beat 3 -> out_valid=0, busy=0, argmax_valid=0, err=0 immediately. The next full frame then drains correctly.
- Back-to-back frames: second frame's first dom_ready clears argmax_valid. A second drain with all-zero data gives argmax_idx=0.
